// File: rtl/mem_if_pkg.sv
// -----------------------------------------------------------------------------
// mem_if_pkg
// Shared definitions for the memory initiator and its responder bench:
// default address/data widths and the initiator state encoding.
// -----------------------------------------------------------------------------
package mem_if_pkg;

   localparam int MEM_AW = 16;
   localparam int MEM_DW = 16;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      WAIT_REL = 2'd2
   } mem_state_e;

endpackage

// File: rtl/mem_init_wdog.sv
// -----------------------------------------------------------------------------
// mem_init_wdog
// Watchdog counter for the memory initiator. Counts cycles while enabled and
// flags expiry on the LIMIT-th consecutive enabled cycle since the last clear.
//
// Ports:
//   CLK     - clock, rising edge
//   RST     - asynchronous active-high reset
//   clear   - restart the count (wins over enable)
//   enable  - count this cycle
//   expired - LIMIT enabled cycles have elapsed since clear
// -----------------------------------------------------------------------------
module mem_init_wdog #(
   parameter int LIMIT = 255
) (
   input  logic CLK,
   input  logic RST,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] r_cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (enable) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // Count value LIMIT-1 during an enabled cycle means this is cycle LIMIT.
   assign expired = enable && (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_initiator.sv
// -----------------------------------------------------------------------------
// mem_initiator
// Accepts single read/write commands and runs them on a four-phase
// REQ/ACK responder interface, returning a one-cycle completion pulse.
//
// Ports:
//   CLK, RST                 - clock, asynchronous active-high reset
//   CMD_VALID/CMD_READY      - command handshake (ready only in IDLE)
//   CMD_WEN/ADDR/WDATA       - command contents (1 = write)
//   RSP_VALID/RDATA/ERR      - completion pulse, read data, timeout flag
//   M_REQ/M_WEN/ADDR/DOUT    - request side of the responder interface
//   M_DIN/M_ACK              - read data and acknowledge from responder
//
// Build option: define MEM_INIT_TIMEOUT_EN to abort a transaction that stays
// TIMEOUT_CYCLES cycles in WAIT_ACK or WAIT_REL (completes with RSP_ERR=1).
// Without it the initiator waits indefinitely and RSP_ERR is tied low.
// -----------------------------------------------------------------------------
module mem_initiator
   import mem_if_pkg::*;
#(
   parameter int AW             = MEM_AW,
   parameter int DW             = MEM_DW,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          CMD_VALID,
   output logic          CMD_READY,
   input  logic          CMD_WEN,
   input  logic [AW-1:0] CMD_ADDR,
   input  logic [DW-1:0] CMD_WDATA,
   output logic          RSP_VALID,
   output logic [DW-1:0] RSP_RDATA,
   output logic          RSP_ERR,
   output logic          M_REQ,
   output logic          M_WEN,
   output logic [AW-1:0] M_ADDR,
   output logic [DW-1:0] M_DOUT,
   input  logic [DW-1:0] M_DIN,
   input  logic          M_ACK
);

   mem_state_e    r_state;
   mem_state_e    w_state_nxt;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_dout;
   logic [DW-1:0] r_rdata;
   logic          r_wen;
   logic          r_req;
   logic          r_rsp_valid;
   logic          w_accept;
   logic          w_expired;

   // Ready is forced low while reset is held, not just after it.
   assign CMD_READY = (r_state == IDLE) && !RST;
   assign w_accept  = CMD_VALID && CMD_READY;

`ifdef MEM_INIT_TIMEOUT_EN
   logic w_wdog_clear;
   logic w_wdog_enable;
   logic r_rsp_err;

   assign w_wdog_enable = (r_state != IDLE);
   // Restart on every entry into a waiting state, including WAIT_ACK->WAIT_REL.
   assign w_wdog_clear  = (w_state_nxt != r_state) && (w_state_nxt != IDLE);

   mem_init_wdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wdog (
      .CLK     (CLK),
      .RST     (RST),
      .clear   (w_wdog_clear),
      .enable  (w_wdog_enable),
      .expired (w_expired)
   );

   // Expiry always coincides with the transition that raises RSP_VALID.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_rsp_err <= 1'b0;
      else     r_rsp_err <= w_expired;
   end

   assign RSP_ERR = r_rsp_err;
`else
   assign w_expired = 1'b0;
   assign RSP_ERR   = 1'b0;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // NOTE: next-state defaults to the current state before the case, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) w_state_nxt = WAIT_ACK;
         end
         WAIT_ACK: begin
            // An ACK only counts once our own REQ is up (REQ may be held off).
            if (w_expired)           w_state_nxt = IDLE;
            else if (r_req && M_ACK) w_state_nxt = WAIT_REL;
         end
         WAIT_REL: begin
            if (w_expired || !M_ACK) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_addr      <= '0;
         r_dout      <= '0;
         r_rdata     <= '0;
         r_wen       <= 1'b0;
         r_req       <= 1'b0;
         r_rsp_valid <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_addr <= CMD_ADDR;
                  r_dout <= CMD_WDATA;
                  r_wen  <= CMD_WEN;
                  // Never raise REQ into a still-high ACK from a prior cycle.
                  r_req  <= !M_ACK;
               end
            end
            WAIT_ACK: begin
               if (w_expired) begin
                  r_req       <= 1'b0;
                  r_rsp_valid <= 1'b1;
               end else if (!r_req) begin
                  r_req <= !M_ACK;
               end else if (M_ACK) begin
                  r_req <= 1'b0;
                  if (!r_wen) r_rdata <= M_DIN;
               end
            end
            WAIT_REL: begin
               if (w_expired || !M_ACK) r_rsp_valid <= 1'b1;
            end
            default: r_req <= 1'b0;
         endcase
      end
   end

   assign RSP_VALID = r_rsp_valid;
   assign RSP_RDATA = r_rdata;
   assign M_REQ     = r_req;
   assign M_WEN     = r_wen;
   assign M_ADDR    = r_addr;
   assign M_DOUT    = r_dout;

endmodule

// File: tb/tb_mem_initiator.sv
// -----------------------------------------------------------------------------
// tb_mem_initiator
// Directed bench for mem_initiator with a registered four-phase responder
// model (per-transaction ACK/release delays) and a response monitor.
// -----------------------------------------------------------------------------
module tb_mem_initiator;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int TO = 8;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          CMD_VALID = 1'b0;
   logic          CMD_READY;
   logic          CMD_WEN = 1'b0;
   logic [AW-1:0] CMD_ADDR = '0;
   logic [DW-1:0] CMD_WDATA = '0;
   logic          RSP_VALID;
   logic [DW-1:0] RSP_RDATA;
   logic          RSP_ERR;
   logic          M_REQ;
   logic          M_WEN;
   logic [AW-1:0] M_ADDR;
   logic [DW-1:0] M_DOUT;
   logic [DW-1:0] M_DIN = '0;
   logic          M_ACK;

   logic          resp_ack  = 1'b0;
   logic          force_ack = 1'b0;
   assign M_ACK = resp_ack | force_ack;

   always #5 CLK = ~CLK;

   mem_initiator #(
      .AW             (AW),
      .DW             (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .CMD_VALID (CMD_VALID),
      .CMD_READY (CMD_READY),
      .CMD_WEN   (CMD_WEN),
      .CMD_ADDR  (CMD_ADDR),
      .CMD_WDATA (CMD_WDATA),
      .RSP_VALID (RSP_VALID),
      .RSP_RDATA (RSP_RDATA),
      .RSP_ERR   (RSP_ERR),
      .M_REQ     (M_REQ),
      .M_WEN     (M_WEN),
      .M_ADDR    (M_ADDR),
      .M_DOUT    (M_DOUT),
      .M_DIN     (M_DIN),
      .M_ACK     (M_ACK)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   // ---------------- responder model ----------------
   logic [DW-1:0] mem [0:255] = '{default: '0};
   int  ack_dly [0:31] = '{default: 0};
   int  rel_dly [0:31] = '{default: 0};
   int  resp_txn = 0;
   int  resp_cnt = 0;
   bit  resp_en  = 1'b1;

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         resp_ack <= 1'b0;
         resp_cnt <= 0;
      end else if (M_REQ && !resp_ack) begin
         if (resp_en && resp_cnt >= ack_dly[resp_txn % 32]) begin
            resp_ack <= 1'b1;
            resp_cnt <= 0;
            if (M_WEN) mem[M_ADDR[7:0]] <= M_DOUT;
            else       M_DIN <= mem[M_ADDR[7:0]];
         end else begin
            resp_cnt <= resp_cnt + 1;
         end
      end else if (!M_REQ && resp_ack) begin
         if (resp_cnt >= rel_dly[resp_txn % 32]) begin
            resp_ack <= 1'b0;
            resp_cnt <= 0;
            resp_txn <= resp_txn + 1;
         end else begin
            resp_cnt <= resp_cnt + 1;
         end
      end
   end

   // ---------------- response monitor ----------------
   int            rsp_n = 0;
   int            rsp_cyc_q [$];
   logic [DW-1:0] rsp_data_q [$];
   logic          rsp_err_q [$];
   int            viol = 0;
   logic          prev_req = 1'b0;
   logic          prev_ack = 1'b0;

   always @(negedge CLK) begin
      #1;
      if (RSP_VALID === 1'b1) begin
         rsp_n++;
         rsp_cyc_q.push_back(cyc);
         rsp_data_q.push_back(RSP_RDATA);
         rsp_err_q.push_back(RSP_ERR);
      end
      if (M_REQ === 1'b1 && prev_req === 1'b0 && prev_ack === 1'b1) viol++;
      prev_req = M_REQ;
      prev_ack = M_ACK;
   end

   // ---------------- helpers (stimulus only) ----------------
   task automatic send(input logic wen, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, output int acc);
      @(negedge CLK);
      CMD_WEN   = wen;
      CMD_ADDR  = addr;
      CMD_WDATA = data;
      CMD_VALID = 1'b1;
      acc = -1;
      for (int i = 0; i < 50; i++) begin
         if (CMD_READY === 1'b1) begin
            acc = cyc + 1;
            break;
         end
         @(negedge CLK);
      end
      @(negedge CLK);
      CMD_VALID = 1'b0;
      total++;
      if (acc < 0) begin
         bad++;
         $display("FAIL accept: CMD_READY never high for addr %h", addr);
      end
   endtask

   task automatic wait_rsp(input int n0, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge CLK); #2;
         if (rsp_n > n0) begin
            ok = 1'b1;
            break;
         end
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL rsp_wait: no RSP_VALID within %0d cycles", budget);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      total++;
      if ({CMD_READY, M_REQ, M_WEN, RSP_VALID, RSP_ERR} !== 5'b0) begin
         bad++;
         $display("FAIL reset_ctrl: ready/req/wen/valid/err=%b want 00000",
                  {CMD_READY, M_REQ, M_WEN, RSP_VALID, RSP_ERR});
      end
      total++;
      if (M_ADDR !== 16'h0 || M_DOUT !== 16'h0 || RSP_RDATA !== 16'h0) begin
         bad++;
         $display("FAIL reset_data: addr=%h dout=%h rdata=%h want 0",
                  M_ADDR, M_DOUT, RSP_RDATA);
      end
      RST = 1'b0;
      #1;
      total++;
      if (CMD_READY !== 1'b1) begin
         bad++;
         $display("FAIL reset_release_ready: got %b want 1", CMD_READY);
      end
   endtask

   task automatic test_write();
      int acc; bit ok; int n0; bit hold_bad;
      hold_bad = 1'b0;
      n0 = rsp_n;
      ack_dly[resp_txn % 32] = 0;
      rel_dly[resp_txn % 32] = 0;
      send(1'b1, 16'h0010, 16'hBEEF, acc);
      total++;
      if (M_REQ !== 1'b1) begin
         bad++;
         $display("FAIL write_req: M_REQ=%b want 1 cycle after accept", M_REQ);
      end
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (M_REQ === 1'b1 &&
             (M_ADDR !== 16'h0010 || M_DOUT !== 16'hBEEF || M_WEN !== 1'b1))
            hold_bad = 1'b1;
         @(negedge CLK); #2;
         ok = (rsp_n > n0);
      end
      total++;
      if (hold_bad) begin
         bad++;
         $display("FAIL write_hold: M_ADDR/M_DOUT/M_WEN changed, want 0010/BEEF/1");
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL write_rsp: no RSP_VALID");
      end else begin
         total++;
         if (rsp_cyc_q[n0] - acc != 4) begin
            bad++;
            $display("FAIL write_latency: got %0d want 4", rsp_cyc_q[n0] - acc);
         end
         total++;
         if (rsp_err_q[n0] !== 1'b0) begin
            bad++;
            $display("FAIL write_err: got %b want 0", rsp_err_q[n0]);
         end
         @(negedge CLK); #2;
         total++;
         if (RSP_VALID !== 1'b0) begin
            bad++;
            $display("FAIL write_pulse_width: RSP_VALID=%b want 0 after one cycle", RSP_VALID);
         end
      end
   endtask

   task automatic test_read();
      int acc; bit ok; int n0;
      n0 = rsp_n;
      ack_dly[resp_txn % 32] = 0;
      rel_dly[resp_txn % 32] = 0;
      send(1'b0, 16'h0010, 16'h0000, acc);
      wait_rsp(n0, 20, ok);
      if (ok) begin
         total++;
         if (rsp_data_q[n0] !== 16'hBEEF) begin
            bad++;
            $display("FAIL read_data: got %h want BEEF", rsp_data_q[n0]);
         end
         total++;
         if (rsp_cyc_q[n0] - acc != 4 || rsp_err_q[n0] !== 1'b0) begin
            bad++;
            $display("FAIL read_latency_err: lat=%0d err=%b want 4/0",
                     rsp_cyc_q[n0] - acc, rsp_err_q[n0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] addr_t [0:2];
      logic [DW-1:0] data_t [0:2];
      logic          wen_t  [0:2];
      logic [AW-1:0] cur_addr;
      int n0, v0, k, first_acc, t0;
      bit hold_bad;
      addr_t = '{16'h0020, 16'h0022, 16'h0022};
      data_t = '{16'h1111, 16'h2222, 16'h0000};
      wen_t  = '{1'b1, 1'b1, 1'b0};
      t0 = resp_txn;
      ack_dly[t0 % 32]       = 0; rel_dly[t0 % 32]       = 0;
      ack_dly[(t0 + 1) % 32] = 5; rel_dly[(t0 + 1) % 32] = 5;
      ack_dly[(t0 + 2) % 32] = 2; rel_dly[(t0 + 2) % 32] = 2;
      n0 = rsp_n; v0 = viol; k = 0; first_acc = -1;
      hold_bad = 1'b0; cur_addr = '0;
      @(negedge CLK);
      CMD_WEN = wen_t[0]; CMD_ADDR = addr_t[0]; CMD_WDATA = data_t[0];
      CMD_VALID = 1'b1;
      for (int i = 0; i < 100 && k < 3; i++) begin
         if (M_REQ === 1'b1 && k > 0 && M_ADDR !== cur_addr) hold_bad = 1'b1;
         if (CMD_READY === 1'b1) begin
            if (k == 0) first_acc = cyc + 1;
            cur_addr = addr_t[k];
            k++;
            @(negedge CLK);
            if (k < 3) begin
               CMD_WEN = wen_t[k]; CMD_ADDR = addr_t[k]; CMD_WDATA = data_t[k];
            end else begin
               CMD_VALID = 1'b0;
            end
         end else begin
            @(negedge CLK);
         end
      end
      CMD_VALID = 1'b0;
      for (int i = 0; i < 60 && rsp_n < n0 + 3; i++) begin
         if (M_REQ === 1'b1 && M_ADDR !== cur_addr) hold_bad = 1'b1;
         @(negedge CLK); #2;
      end
      repeat (5) @(negedge CLK);
      #2;
      total++;
      if (rsp_n - n0 != 3) begin
         bad++;
         $display("FAIL b2b_count: got %0d responses want 3", rsp_n - n0);
      end
      total++;
      if (hold_bad) begin
         bad++;
         $display("FAIL b2b_hold: M_ADDR changed while M_REQ high");
      end
      total++;
      if (viol != v0) begin
         bad++;
         $display("FAIL b2b_handshake: %0d REQ rises while ACK high, want 0", viol - v0);
      end
      if (rsp_n - n0 >= 3) begin
         total++;
         if (rsp_cyc_q[n0] - first_acc != 4 || rsp_cyc_q[n0 + 1] - first_acc != 19 ||
             rsp_cyc_q[n0 + 2] - first_acc != 28) begin
            bad++;
            $display("FAIL b2b_timing: got %0d/%0d/%0d want 4/19/28",
                     rsp_cyc_q[n0] - first_acc, rsp_cyc_q[n0 + 1] - first_acc,
                     rsp_cyc_q[n0 + 2] - first_acc);
         end
         total++;
         if (rsp_data_q[n0] !== 16'hBEEF || rsp_data_q[n0 + 2] !== 16'h2222) begin
            bad++;
            $display("FAIL b2b_data: got %h/%h want BEEF/2222",
                     rsp_data_q[n0], rsp_data_q[n0 + 2]);
         end
         total++;
         if ({rsp_err_q[n0], rsp_err_q[n0 + 1], rsp_err_q[n0 + 2]} !== 3'b000) begin
            bad++;
            $display("FAIL b2b_err: RSP_ERR set on a normal completion");
         end
      end
   endtask

   task automatic test_ack_idle();
      int acc; bit ok; int n0, v0; bit idle_bad, req_bad;
      idle_bad = 1'b0; req_bad = 1'b0;
      n0 = rsp_n; v0 = viol;
      @(negedge CLK);
      force_ack = 1'b1;
      repeat (3) begin
         @(negedge CLK); #2;
         if (CMD_READY !== 1'b1 || RSP_VALID !== 1'b0) idle_bad = 1'b1;
      end
      total++;
      if (idle_bad || rsp_n != n0) begin
         bad++;
         $display("FAIL ack_in_idle: ready=%b rsp_count=%0d want 1/0",
                  CMD_READY, rsp_n - n0);
      end
      ack_dly[resp_txn % 32] = 0;
      rel_dly[resp_txn % 32] = 0;
      send(1'b1, 16'h0040, 16'h4444, acc);
      for (int i = 0; i < 3; i++) begin
         if (M_REQ !== 1'b0) req_bad = 1'b1;
         @(negedge CLK);
      end
      total++;
      if (req_bad) begin
         bad++;
         $display("FAIL req_held_off: M_REQ high while ACK still high, want 0");
      end
      force_ack = 1'b0;
      @(negedge CLK);
      total++;
      if (M_REQ !== 1'b1) begin
         bad++;
         $display("FAIL req_after_release: M_REQ=%b want 1", M_REQ);
      end
      wait_rsp(n0, 20, ok);
      total++;
      if (viol != v0) begin
         bad++;
         $display("FAIL ack_handshake: %0d REQ rises while ACK high, want 0", viol - v0);
      end
   endtask

   task automatic test_reset_mid();
      int acc; int n0;
      resp_en = 1'b0;
      send(1'b0, 16'h0030, 16'h0000, acc);
      @(negedge CLK);
      total++;
      if (M_REQ !== 1'b1) begin
         bad++;
         $display("FAIL mid_req: M_REQ=%b want 1 before reset", M_REQ);
      end
      n0 = rsp_n;
      #2 RST = 1'b1;
      #1;
      total++;
      if (M_REQ !== 1'b0 || CMD_READY !== 1'b0 || RSP_VALID !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_async: req/ready/valid=%b%b%b want 000",
                  M_REQ, CMD_READY, RSP_VALID);
      end
      repeat (2) @(negedge CLK);
      total++;
      if (M_ADDR !== 16'h0 || RSP_RDATA !== 16'h0) begin
         bad++;
         $display("FAIL mid_reset_data: addr=%h rdata=%h want 0/0", M_ADDR, RSP_RDATA);
      end
      RST = 1'b0;
      resp_en = 1'b1;
      @(negedge CLK);
      total++;
      if (CMD_READY !== 1'b1) begin
         bad++;
         $display("FAIL mid_release_ready: got %b want 1", CMD_READY);
      end
      repeat (8) @(negedge CLK);
      #2;
      total++;
      if (rsp_n != n0) begin
         bad++;
         $display("FAIL mid_abort: got %0d responses want 0", rsp_n - n0);
      end
   endtask

   task automatic test_timeout();
      int acc; int n0;
`ifdef MEM_INIT_TIMEOUT_EN
      bit ok;
`else
      bit hold_bad;
`endif
      resp_en = 1'b0;
      n0 = rsp_n;
      send(1'b0, 16'h0050, 16'h0000, acc);
`ifdef MEM_INIT_TIMEOUT_EN
      wait_rsp(n0, 30, ok);
      if (ok) begin
         total++;
         if (rsp_cyc_q[n0] - acc != TO) begin
            bad++;
            $display("FAIL timeout_latency: got %0d want %0d", rsp_cyc_q[n0] - acc, TO);
         end
         total++;
         if (rsp_err_q[n0] !== 1'b1 || rsp_data_q[n0] !== 16'h0) begin
            bad++;
            $display("FAIL timeout_rsp: err=%b rdata=%h want 1/0000",
                     rsp_err_q[n0], rsp_data_q[n0]);
         end
         total++;
         if (M_REQ !== 1'b0) begin
            bad++;
            $display("FAIL timeout_req: M_REQ=%b want 0", M_REQ);
         end
      end
`else
      hold_bad = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (M_REQ !== 1'b1) hold_bad = 1'b1;
         @(negedge CLK);
      end
      #2;
      total++;
      if (hold_bad || rsp_n != n0) begin
         bad++;
         $display("FAIL no_timeout: req_dropped=%b responses=%0d want 0/0",
                  hold_bad, rsp_n - n0);
      end
`endif
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      resp_en = 1'b1;
      @(negedge CLK);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_ack_idle();
      test_reset_mid();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
